mode_sequencer: RTL and testbench
=================================

# mode_sequencer

Top-level supervisor that drives the enable/sync side of the traffic-light mode blocks and consumes their phase-complete feedback. It selects which of two mode blocks (mode 1: fixed timing, mode 2: sensor-driven) owns the light and hands the global light state across on a switch. It only changes the owner at a phase boundary, and it muxes the owner's light and countdown onto the display path. It sits between the mode-select switches and the mode blocks.

## Interface
- SYNC_CYCLES, 100_000_000: clk cycles `enb` is held low during hand-over; must cover at least one mode-block 1 s tick plus margin.
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- run  input  1  1 = lights operating, 0 = controlled all-red stop.
- mode_sel  input  1  requested owner: 0 = mode 1, 1 = mode 2.
- fb_m1, fb_m2  input  1  phase-complete feedback from each mode block; level, several clk cycles wide.
- state_m1, state_m2  input  2  currentState of each mode block (00 RED, 01 YELLOW, 10 GREEN, 11 UNDEFINED).
- light_m1, light_m2  input  2  light output of each mode block.
- time_m1, time_m2  input  5  lightTime of each mode block.
- enb_m1, enb_m2  output  1  per-block enable; at most one high.
- set  output  1  run strobe to mode blocks; high only in RUN.
- last_state  output  2  global state handed to the block being synced.
- light  output  2  displayed light.
- light_time  output  5  displayed countdown.
- active  output  1  current owner (0 = mode 1, 1 = mode 2).
- busy  output  1  high in SYNC.
- fault  output  1  sticky fault flag.

## Operation
- States: IDLE, SYNC, RUN, FAULT.
- Reset values: state IDLE, enb_m1 = enb_m2 = 0, set = 0, last_state = 00, light = 00, light_time = 0, active = 0, busy = 0, fault = 0, sync counter 0, fb edge registers 0.
- IDLE: both enb low, set = 0, light = RED, light_time = 0. If run = 1, then active <= mode_sel, last_state <= RED, counter cleared, go to SYNC.
- SYNC: both enb low, busy = 1, last_state held, light = RED, light_time = 0.
  - Counter increments each cycle.
  - When counter = SYNC_CYCLES-1, go to RUN with the selected enb and set rising the next cycle.
- RUN: enb of active = 1, other enb = 0, set = 1. light/light_time = active block's light_x/time_x, registered one cycle.
  - fb edge = registered rising edge of fb of the active block; the inactive block's fb is ignored.
  - On fb edge with mode_sel != active, the switch fires:
    - last_state <= state of the active block in that cycle, i.e. the phase just finished.
    - active <= mode_sel, counter cleared, go to SYNC.
  - On fb edge with mode_sel == active, stay in RUN.
- FAULT entry and behaviour:
  - Entry: in RUN, active block's state = 11 for 2 consecutive cycles.
  - Both enb low, set = 0, fault = 1, light = YELLOW (01), light_time = 0.
  - Exit only by rst_n.
- run = 0 in SYNC or RUN: go to IDLE the next cycle, regardless of feedback. Light is RED from that cycle.
- Priority in one cycle: FAULT > run = 0 > switch > hold.
- mode_sel changes while in SYNC are ignored; they are re-evaluated at the next fb edge in RUN.

## Timing
- All outputs are registered; no combinational path from input to output.
- IDLE to first enb high: exactly SYNC_CYCLES + 1 cycles after the run = 1 sample.
- Switch: enb of the old owner drops 1 cycle after the fb edge is detected. The new owner's enb rises SYNC_CYCLES + 1 cycles later.
- last_state is stable for the whole SYNC interval.
- fb edge detect adds 1 cycle after fb rises. A level-high fb on RUN entry does not count as an edge.
- rst_n low at any time forces reset values immediately (asynchronously). Released state is IDLE.

## Test plan
All scenarios use SYNC_CYCLES = 4.
- Reset and start: release rst_n, run = 1, mode_sel = 0 → busy high for 4 cycles, enb_m1 = 1 and set = 1 at cycle 5, last_state = 00, light follows light_m1 one cycle later.
- Boundary switch: in RUN with active = 0, mode_sel = 1, state_m1 = 10, fb_m1 rises → enb_m1 = 0 two cycles after fb rises, last_state = 10, active = 1, enb_m2 = 1 after 4 more SYNC cycles + 1.
- Deferred switch: toggle mode_sel in mid-phase without fb → enb_m1 stays 1 and active stays 0 until the next fb_m1 rise.
- Ignore inactive feedback: active = 1, pulse fb_m1 with mode_sel = 0 → no state change; switch happens only on fb_m2 rise.
- Stop: run = 0 during RUN → next cycle both enb = 0, set = 0, light = 00, state IDLE; run = 1 again → fresh 4-cycle SYNC.
- Fault: state_m1 = 11 for 2 cycles in RUN → fault = 1, light = 01, enb low; toggling run/mode_sel has no effect until rst_n pulse restores reset values.

Source files
------------

// File: rtl/mode_sequencer_if.sv
// Mode-select / mode-block handshake bundle for mode_sequencer.
// master = stimulus side (switches + mode blocks), slave = the sequencer.
interface mode_sequencer_if;
    logic       run;
    logic       mode_sel;
    logic       fb_m1;
    logic       fb_m2;
    logic [1:0] state_m1;
    logic [1:0] state_m2;
    logic [1:0] light_m1;
    logic [1:0] light_m2;
    logic [4:0] time_m1;
    logic [4:0] time_m2;
    logic       enb_m1;
    logic       enb_m2;
    logic       set;
    logic [1:0] last_state;
    logic [1:0] light;
    logic [4:0] light_time;
    logic       active;
    logic       busy;
    logic       fault;

    modport master (
        output run, mode_sel, fb_m1, fb_m2, state_m1, state_m2,
               light_m1, light_m2, time_m1, time_m2,
        input  enb_m1, enb_m2, set, last_state, light, light_time,
               active, busy, fault
    );

    modport slave (
        input  run, mode_sel, fb_m1, fb_m2, state_m1, state_m2,
               light_m1, light_m2, time_m1, time_m2,
        output enb_m1, enb_m2, set, last_state, light, light_time,
               active, busy, fault
    );
endinterface

// File: rtl/mode_sequencer.sv
// Supervisor choosing which traffic-light mode block owns the light; hands the
// global light state across at phase boundaries and muxes the owner to the display.
module mode_sequencer #(
    parameter int unsigned SYNC_CYCLES = 100_000_000
) (
    input  logic            clk,
    input  logic            rst_n,
    mode_sequencer_if.slave bus
);
    localparam int unsigned CW     = (SYNC_CYCLES > 1) ? $clog2(SYNC_CYCLES) : 1;
    localparam logic [1:0]  RED    = 2'b00;
    localparam logic [1:0]  YELLOW = 2'b01;
    localparam logic [1:0]  UNDEF  = 2'b11;

    typedef enum logic [1:0] {IDLE, SYNC, RUN, FAULT} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;
    logic [1:0]    last_q, last_d;
    logic          bad_q, bad_d;
    logic          fb1_q, fb2_q;
    logic          edge_q, edge_d;
    logic          enb1_q, enb1_d, enb2_q, enb2_d;
    logic          set_q, set_d, busy_q, busy_d, fault_q, fault_d;
    logic [1:0]    light_q, light_d;
    logic [4:0]    time_q, time_d;

    logic          fb_act, fb_act_q;
    logic [1:0]    st_act, light_act;
    logic [4:0]    time_act;

    // Owner view: only the active block's feedback and state are ever looked at
    always_comb begin
        fb_act    = active_q ? bus.fb_m2    : bus.fb_m1;
        fb_act_q  = active_q ? fb2_q        : fb1_q;
        st_act    = active_q ? bus.state_m2 : bus.state_m1;
        light_act = active_q ? bus.light_m2 : bus.light_m1;
        time_act  = active_q ? bus.time_m2  : bus.time_m1;
    end

    // Next state plus next output values; outputs follow the current state one cycle later
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        active_d = active_q;
        last_d   = last_q;
        bad_d    = 1'b0;
        edge_d   = (state_q == RUN) && fb_act && !fb_act_q;
        enb1_d   = 1'b0;
        enb2_d   = 1'b0;
        set_d    = 1'b0;
        busy_d   = 1'b0;
        fault_d  = 1'b0;
        light_d  = RED;
        time_d   = 5'd0;

        case (state_q)
            IDLE: begin
                if (bus.run) begin
                    state_d  = SYNC;
                    active_d = bus.mode_sel;
                    last_d   = RED;
                    cnt_d    = '0;
                end
            end
            SYNC: begin
                busy_d = 1'b1;
                if (!bus.run) begin
                    state_d = IDLE;
                end else if (cnt_q == CW'(SYNC_CYCLES - 1)) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RUN: begin
                enb1_d  = !active_q;
                enb2_d  = active_q;
                set_d   = 1'b1;
                light_d = light_act;
                time_d  = time_act;
                bad_d   = (st_act == UNDEF);
                // Fault outranks stop, stop outranks an owner switch
                if (bad_q && (st_act == UNDEF)) begin
                    state_d = FAULT;
                end else if (!bus.run) begin
                    state_d = IDLE;
                end else if (edge_q && (bus.mode_sel != active_q)) begin
                    state_d  = SYNC;
                    last_d   = st_act;
                    active_d = bus.mode_sel;
                    cnt_d    = '0;
                end
            end
            FAULT: begin
                fault_d = 1'b1;
                light_d = YELLOW;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            active_q <= 1'b0;
            last_q   <= RED;
            bad_q    <= 1'b0;
            fb1_q    <= 1'b0;
            fb2_q    <= 1'b0;
            edge_q   <= 1'b0;
            enb1_q   <= 1'b0;
            enb2_q   <= 1'b0;
            set_q    <= 1'b0;
            busy_q   <= 1'b0;
            fault_q  <= 1'b0;
            light_q  <= RED;
            time_q   <= 5'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            active_q <= active_d;
            last_q   <= last_d;
            bad_q    <= bad_d;
            fb1_q    <= bus.fb_m1;
            fb2_q    <= bus.fb_m2;
            edge_q   <= edge_d;
            enb1_q   <= enb1_d;
            enb2_q   <= enb2_d;
            set_q    <= set_d;
            busy_q   <= busy_d;
            fault_q  <= fault_d;
            light_q  <= light_d;
            time_q   <= time_d;
        end
    end

    assign bus.enb_m1     = enb1_q;
    assign bus.enb_m2     = enb2_q;
    assign bus.set        = set_q;
    assign bus.last_state = last_q;
    assign bus.light      = light_q;
    assign bus.light_time = time_q;
    assign bus.active     = active_q;
    assign bus.busy       = busy_q;
    assign bus.fault      = fault_q;
endmodule

// File: tb/tb_mode_sequencer.sv
// Scenario bench for mode_sequencer with SYNC_CYCLES = 4 and randomized mode-block traffic.
module tb_mode_sequencer;
    localparam int unsigned S = 4;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    mode_sequencer_if bus();

    mode_sequencer #(.SYNC_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // {enb_m1, enb_m2, set, busy, fault, active}
    function automatic logic [5:0] flags();
        return {bus.enb_m1, bus.enb_m2, bus.set, bus.busy, bus.fault, bus.active};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Random mode-block traffic; block states never UNDEFINED here
    task automatic rand_inputs();
        bus.light_m1 = 2'($urandom_range(3));
        bus.light_m2 = 2'($urandom_range(3));
        bus.time_m1  = 5'($urandom);
        bus.time_m2  = 5'($urandom);
        bus.state_m1 = 2'($urandom_range(2));
        bus.state_m2 = 2'($urandom_range(2));
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.run = 1'b0; bus.mode_sel = 1'b0; bus.fb_m1 = 1'b0; bus.fb_m2 = 1'b0;
        rand_inputs();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({flags(), bus.last_state, bus.light, bus.light_time} !== 15'd0) begin
            errors++;
            $display("FAIL reset_values: got %b required 0", {flags(), bus.last_state, bus.light, bus.light_time});
        end
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
        end
        checks++;
        if ({flags(), bus.light, bus.light_time} !== 13'd0) begin
            errors++;
            $display("FAIL idle_hold: got %b required 0", {flags(), bus.light, bus.light_time});
        end
    endtask

    // run sampled at edge 0: busy on edges 1..S, owner enabled from edge S+1
    task automatic start_checked(input string tag);
        logic [5:0] want;
        logic [1:0] lm;
        logic [4:0] tm;
        bus.mode_sel = 1'b0;
        bus.run      = 1'b1;
        for (int k = 0; k <= int'(S) + 1; k++) begin
            rand_inputs();
            lm = bus.light_m1;
            tm = bus.time_m1;
            tick();
            want = {k > int'(S), 1'b0, k > int'(S), (k >= 1 && k <= int'(S)), 2'b00};
            checks++;
            if (flags() !== want) begin
                errors++;
                $display("FAIL %s_flags edge %0d: got %b required %b", tag, k, flags(), want);
            end
            checks++;
            if ({bus.last_state, bus.light, bus.light_time} !==
                ((k > int'(S)) ? {2'b00, lm, tm} : 9'd0)) begin
                errors++;
                $display("FAIL %s_display edge %0d: got %b required %b", tag, k,
                         {bus.last_state, bus.light, bus.light_time},
                         (k > int'(S)) ? {2'b00, lm, tm} : 9'd0);
            end
        end
    endtask

    task automatic test_start();
        logic [1:0] lm;
        logic [4:0] tm;
        start_checked("start");
        for (int k = 0; k < 12; k++) begin
            rand_inputs();
            lm = bus.light_m1;
            tm = bus.time_m1;
            tick();
            checks++;
            if ({flags(), bus.light, bus.light_time} !== {6'b101000, lm, tm}) begin
                errors++;
                $display("FAIL run_follow cycle %0d: got %b required %b", k,
                         {flags(), bus.light, bus.light_time}, {6'b101000, lm, tm});
            end
        end
    endtask

    // mode_sel flips mid-phase; owner holds until the owner's own fb rises
    task automatic test_deferred();
        bus.mode_sel = 1'b1;
        for (int k = 0; k < 12; k++) begin
            rand_inputs();
            bus.fb_m2 = (k >= 3 && k < 7);
            tick();
            checks++;
            if (flags() !== 6'b101000) begin
                errors++;
                $display("FAIL deferred cycle %0d: got %b required 101000", k, flags());
            end
        end
        bus.fb_m2 = 1'b0;
    endtask

    task automatic test_switch();
        logic [5:0] want;
        logic [1:0] lm;
        rand_inputs();
        bus.state_m1 = 2'b10;
        bus.fb_m1    = 1'b1;
        tick();
        checks++;
        if (flags() !== 6'b101000) begin
            errors++;
            $display("FAIL switch_edge: got %b required 101000", flags());
        end
        tick();
        checks++;
        if ({flags(), bus.last_state} !== {6'b101001, 2'b10}) begin
            errors++;
            $display("FAIL switch_fire: got %b required %b", {flags(), bus.last_state}, {6'b101001, 2'b10});
        end
        for (int j = 2; j <= 7; j++) begin
            rand_inputs();
            bus.fb_m1    = 1'($urandom);
            bus.mode_sel = (j >= 5) ? 1'b1 : 1'($urandom);
            lm = bus.light_m2;
            tick();
            want = (j <= 5) ? 6'b000101 : 6'b011001;
            checks++;
            if ({flags(), bus.last_state} !== {want, 2'b10}) begin
                errors++;
                $display("FAIL switch_sync edge +%0d: got %b required %b", j,
                         {flags(), bus.last_state}, {want, 2'b10});
            end
            if (j >= 6) begin
                checks++;
                if (bus.light !== lm) begin
                    errors++;
                    $display("FAIL switch_light edge +%0d: got %b required %b", j, bus.light, lm);
                end
            end
        end
        bus.fb_m1 = 1'b0;
    endtask

    task automatic test_ignore_inactive();
        logic [5:0] want;
        logic [1:0] v;
        bus.mode_sel = 1'b0;
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            bus.fb_m1 = (k >= 2 && k < 6);
            tick();
            checks++;
            if (flags() !== 6'b011001) begin
                errors++;
                $display("FAIL ignore_m1 cycle %0d: got %b required 011001", k, flags());
            end
        end
        bus.fb_m1 = 1'b0;
        rand_inputs();
        v = 2'($urandom_range(2));
        bus.state_m2 = v;
        bus.fb_m2    = 1'b1;
        tick();
        tick();
        checks++;
        if ({flags(), bus.last_state} !== {6'b011000, v}) begin
            errors++;
            $display("FAIL back_fire: got %b required %b", {flags(), bus.last_state}, {6'b011000, v});
        end
        // fb_m1 already high when mode 1 takes over must not count as a boundary
        bus.fb_m1    = 1'b1;
        bus.mode_sel = 1'b1;
        for (int j = 2; j <= 12; j++) begin
            rand_inputs();
            tick();
            want = (j <= 5) ? 6'b000100 : 6'b101000;
            checks++;
            if ({flags(), bus.last_state} !== {want, v}) begin
                errors++;
                $display("FAIL back_sync edge +%0d: got %b required %b", j, {flags(), bus.last_state}, {want, v});
            end
        end
        bus.fb_m1    = 1'b0;
        bus.fb_m2    = 1'b0;
        bus.mode_sel = 1'b0;
        tick();
    endtask

    task automatic test_stop();
        bus.run = 1'b0;
        rand_inputs();
        tick();
        checks++;
        if (flags() !== 6'b101000) begin
            errors++;
            $display("FAIL stop_edge: got %b required 101000", flags());
        end
        for (int k = 0; k < 3; k++) begin
            rand_inputs();
            tick();
            checks++;
            if ({flags(), bus.light, bus.light_time} !== 13'd0) begin
                errors++;
                $display("FAIL stop_idle cycle %0d: got %b required 0", k, {flags(), bus.light, bus.light_time});
            end
        end
        start_checked("restart");
        // drop run while still synchronising
        bus.run = 1'b0;
        tick();
        tick();
        bus.run = 1'b1;
        tick();
        tick();
        bus.run = 1'b0;
        tick();
        checks++;
        if (flags() !== 6'b000100) begin
            errors++;
            $display("FAIL sync_stop_edge: got %b required 000100", flags());
        end
        for (int k = 0; k < 8; k++) begin
            rand_inputs();
            tick();
            checks++;
            if (flags() !== 6'b000000) begin
                errors++;
                $display("FAIL sync_stop_idle cycle %0d: got %b required 000000", k, flags());
            end
        end
        start_checked("resume");
    endtask

    task automatic test_fault();
        // a single UNDEFINED cycle is tolerated
        rand_inputs();
        bus.state_m1 = 2'b11;
        tick();
        rand_inputs();
        bus.state_m1 = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (flags() !== 6'b101000) begin
                errors++;
                $display("FAIL fault_single cycle %0d: got %b required 101000", k, flags());
            end
            rand_inputs();
        end
        bus.state_m1 = 2'b11;
        tick();
        bus.run = 1'b0;
        tick();
        checks++;
        if (flags() !== 6'b101000) begin
            errors++;
            $display("FAIL fault_entry: got %b required 101000", flags());
        end
        for (int k = 0; k < 10; k++) begin
            rand_inputs();
            bus.run      = 1'($urandom);
            bus.mode_sel = 1'($urandom);
            bus.fb_m1    = 1'($urandom);
            bus.fb_m2    = 1'($urandom);
            tick();
            checks++;
            if ({flags(), bus.light, bus.light_time} !== {6'b000010, 2'b01, 5'd0}) begin
                errors++;
                $display("FAIL fault_hold cycle %0d: got %b required %b", k,
                         {flags(), bus.light, bus.light_time}, {6'b000010, 2'b01, 5'd0});
            end
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({flags(), bus.last_state, bus.light, bus.light_time} !== 15'd0) begin
            errors++;
            $display("FAIL async_reset: got %b required 0", {flags(), bus.last_state, bus.light, bus.light_time});
        end
        #2;
        rst_n   = 1'b1;
        bus.run = 1'b0;
        tick();
        tick();
        checks++;
        if ({flags(), bus.light} !== 8'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %b required 0", {flags(), bus.light});
        end
    endtask

    initial begin
        test_reset();
        test_start();
        test_deferred();
        test_switch();
        test_ignore_inactive();
        test_stop();
        test_fault();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
